arm_cpu_self_test: RTL
======================

Name: arm_cpu_self_test

Overview:
- Synthesisable, parametrised vector sequencer that exercises the ArmCpu memory-side interface in hardware.
- Vectors are held in an internal table. For each vector the block resets the CPU (or chains from the previous vector), applies instr/read_data, compares data_memory_addr, write_data, mem_write and pc against expected values under per-vector masks, then counts failures.
- Sits between a host/loader and the CPU, on the same clock as the CPU.

Parameters:
- DATA_WIDTH, 32, width of instr, read_data, addresses, data and pc.
- DEPTH, 64, vector table entries; AW = $clog2(DEPTH).
- RESET_CYCLES, 2, cycles cpu_reset is held high before a non-chained vector (>=1).

Ports:
- clk  in  1  clock, shared with CPU
- reset  in  1  synchronous active-high reset
- vec_we  in  1  write strobe for vector table
- vec_addr  in  AW  table write index
- vec_wdata  in  5*DATA_WIDTH+6  {instr, read_data, exp_addr, exp_wdata, exp_pc, flags[5:0]}; flags = {chain, chk_pc, chk_mw, exp_mw, chk_wdata, chk_addr}
- num_vectors  in  AW+1  vectors to run, sampled on start
- start  in  1  run request, accepted only in IDLE or DONE
- busy  out  1  high from accepted start until DONE
- done  out  1  level, high in DONE until next accepted start or reset
- pass  out  1  valid while done: fail_count==0
- fail_count  out  AW+1  failing vectors this run
- first_fail_index  out  AW  index of first failure; valid when fail_count!=0
- cpu_reset  out  1  drives CPU reset
- instr  out  DATA_WIDTH  to CPU
- read_data  out  DATA_WIDTH  to CPU
- pc  in  DATA_WIDTH  from CPU
- mem_write  in  1  from CPU
- write_data  in  DATA_WIDTH  from CPU
- data_memory_addr  in  DATA_WIDTH  from CPU

Behaviour:
- Reset is synchronous and active-high. Reset values: state=IDLE, busy=0, done=0, pass=0, fail_count=0, first_fail_index=0, cpu_reset=1, instr=0, read_data=0, index=0. The table contents are not reset.
- Table: DEPTH x VEC_W, synchronous write on vec_we. Asynchronous read at the current index. Writes while busy are ignored.
- instr and read_data come combinationally from table[index] in RST and EXEC states, and are 0 otherwise. cpu_reset=1 in IDLE, RST and DONE, and 0 in EXEC.
- FSM:
  - IDLE/DONE + start: latch N=num_vectors, clear counters, index=0. If N==0, go to DONE with pass=1. Else go to RST.
  - RST: hold for RESET_CYCLES cycles (down-counter), then go to EXEC.
  - EXEC: exactly one cycle. At the end of the cycle, evaluate mismatch = (chk_addr & addr!=exp_addr) | (chk_wdata & write_data!=exp_wdata) | (chk_mw & mem_write!=exp_mw) | (chk_pc & pc!=exp_pc). The CPU executes the instruction on the same edge.
  - After EXEC: if index==N-1, go to DONE. Else index++. The next state is EXEC if the next vector's chain=1 (CPU state persists, no reset), otherwise RST.
  - chain on vector 0 is ignored; vector 0 always goes through RST.
- Mismatch: fail_count++. On the first mismatch, first_fail_index=index.
- Cycle count:
  - Non-chained vector: RESET_CYCLES+1 cycles.
  - Chained vector: 1 cycle.
  - done rises 1 cycle after the last EXEC.
- pc checks test the pre-edge pc. A post-branch pc is checked by a following chained vector with chk_pc.
- start while busy is ignored. Reset mid-run aborts to IDLE with cpu_reset=1 and counters cleared.
- Outputs pass/fail_count/first_fail_index hold their values in DONE.

Optional Feature:
- Macro: SELF_TEST_STOP_ON_FAIL_EN.
- Defined: the first mismatch sends the FSM straight to DONE after that EXEC; fail_count=1 and the remaining vectors are skipped.
- Undefined: all N vectors always run.

Test Plan:
- Bench uses a stub CPU: data_memory_addr=instr, write_data=read_data, mem_write=instr[20], pc=4*cycles since cpu_reset fell.
- Single vector, RESET_CYCLES=2: instr=32'h000000ff, read_data=7, chk_addr/chk_wdata set with matching expectations, N=1 -> cpu_reset high 2 cycles, EXEC 1 cycle, done on cycle 4 after start, pass=1, fail_count=0.
- Three vectors, vector 1 exp_addr=8 but instr=9 -> fail_count=1, first_fail_index=1, pass=0. With SELF_TEST_STOP_ON_FAIL_EN defined: done 1 cycle after vector 1's EXEC, vector 2 never driven.
- Chaining: vector 1 chain=1, chk_pc, exp_pc=4 -> no cpu_reset between vectors 0 and 1, pass=1. Same vector with chain=0 and exp_pc=4 -> fail (pc=0).
- N=0 -> done and pass=1 the cycle after start, cpu_reset never drops. start pulsed while busy -> no effect on index or counters.
- Reset asserted during RST of vector 2 of 4 -> IDLE next cycle, busy=0, fail_count=0. A new start runs from index 0. vec_we during busy -> table unchanged (read back by rerun).

Source files
------------

// File: rtl/arm_cpu_self_test_if.sv
// ----------------------------------------------------------------------------
// arm_cpu_self_test_if
// Memory-side bus between the self-test sequencer and the CPU under test.
//   master modport (sequencer): drives cpu_reset, instr, read_data;
//                               observes pc, mem_write, write_data,
//                               data_memory_addr.
//   slave modport  (CPU):       the mirror image.
// ----------------------------------------------------------------------------
interface arm_cpu_self_test_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_reset;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] pc;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] data_memory_addr;

  modport master (
    output cpu_reset, instr, read_data,
    input  pc, mem_write, write_data, data_memory_addr
  );

  modport slave (
    input  cpu_reset, instr, read_data,
    output pc, mem_write, write_data, data_memory_addr
  );
endinterface

// File: rtl/arm_cpu_self_test.sv
// ----------------------------------------------------------------------------
// arm_cpu_self_test
// Vector sequencer that exercises the CPU memory-side interface in hardware.
// A table of vectors is loaded by a host; on start each vector is applied to
// the CPU (after a CPU reset, or chained onto the previous vector's state) and
// the CPU outputs are compared against masked expectations.
//
// Ports:
//   clk                 clock shared with the CPU
//   reset               synchronous active-high reset
//   vec_we_i            vector table write strobe (ignored while busy)
//   vec_addr_i          vector table write index
//   vec_wdata_i         {instr, read_data, exp_addr, exp_wdata, exp_pc, flags}
//                       flags = {chain, chk_pc, chk_mw, exp_mw, chk_wdata, chk_addr}
//   num_vectors_i       number of vectors to run, sampled on accepted start
//   start_i             run request, accepted in IDLE or DONE
//   busy_o              run in progress
//   done_o              level, high in DONE
//   pass_o              fail_count_o == 0, valid while done_o
//   fail_count_o        failing vectors in this run
//   first_fail_index_o  index of the first failing vector
//   cpu_if              master side of the CPU bus
//
// Optional feature: define SELF_TEST_STOP_ON_FAIL_EN to end the run at the
// first failing vector.
// ----------------------------------------------------------------------------
module arm_cpu_self_test #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 64,
  parameter  int RESET_CYCLES = 2,
  localparam int AW           = $clog2(DEPTH),
  localparam int VEC_W        = 5 * DATA_WIDTH + 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vec_we_i,
  input  logic [AW-1:0]    vec_addr_i,
  input  logic [VEC_W-1:0] vec_wdata_i,
  input  logic [AW:0]      num_vectors_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [AW:0]      fail_count_o,
  output logic [AW-1:0]    first_fail_index_o,
  arm_cpu_self_test_if.master cpu_if
);

  // Field offsets inside a vector word.
  localparam int F_INSTR  = 4 * DATA_WIDTH + 6;
  localparam int F_RDATA  = 3 * DATA_WIDTH + 6;
  localparam int F_EADDR  = 2 * DATA_WIDTH + 6;
  localparam int F_EWDATA = DATA_WIDTH + 6;
  localparam int F_EPC    = 6;
  localparam int B_CHAIN  = 5;
  localparam int B_CHKPC  = 4;
  localparam int B_CHKMW  = 3;
  localparam int B_EXPMW  = 2;
  localparam int B_CHKWD  = 1;
  localparam int B_CHKAD  = 0;

  localparam int RCW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

`ifdef SELF_TEST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   index_q, index_d;
  logic [AW:0]     n_q, n_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [AW:0]     fail_q, fail_d;
  logic [AW-1:0]   ffi_q, ffi_d;
  logic            pass_q, pass_d;

  // --------------------------------------------------------------------------
  // Vector table: synchronous write, asynchronous read. Not reset.
  // --------------------------------------------------------------------------
  logic [VEC_W-1:0] table_q [DEPTH];

  always_ff @(posedge clk) begin
    if (vec_we_i && !busy_o) begin
      table_q[vec_addr_i] <= vec_wdata_i;
    end
  end

  logic [VEC_W-1:0] cur_vec;
  logic [AW-1:0]    index_inc;
  logic             nxt_chain;

  assign cur_vec   = table_q[index_q];
  assign index_inc = index_q + AW'(1);
  // Chain flag of the vector that would run next decides RST vs direct EXEC.
  assign nxt_chain = table_q[index_inc][B_CHAIN];

  // --------------------------------------------------------------------------
  // Masked comparison of the CPU outputs against the current vector.
  // Only meaningful while in EXEC; evaluated at the end of that cycle.
  // --------------------------------------------------------------------------
  logic mis_addr, mis_wdata, mis_mw, mis_pc, mismatch;

  assign mis_addr  = cur_vec[B_CHKAD] &&
                     (cpu_if.data_memory_addr != cur_vec[F_EADDR +: DATA_WIDTH]);
  assign mis_wdata = cur_vec[B_CHKWD] &&
                     (cpu_if.write_data != cur_vec[F_EWDATA +: DATA_WIDTH]);
  assign mis_mw    = cur_vec[B_CHKMW] &&
                     (cpu_if.mem_write != cur_vec[B_EXPMW]);
  assign mis_pc    = cur_vec[B_CHKPC] &&
                     (cpu_if.pc != cur_vec[F_EPC +: DATA_WIDTH]);
  assign mismatch  = mis_addr || mis_wdata || mis_mw || mis_pc;

  logic last_vec;
  assign last_vec = ({1'b0, index_q} == (n_q - (AW+1)'(1)));

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    n_d     = n_q;
    rcnt_d  = rcnt_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          n_d     = num_vectors_i;
          fail_d  = '0;
          ffi_d   = '0;
          index_d = '0;
          pass_d  = 1'b0;
          if (num_vectors_i == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            // Vector 0 always starts from a CPU reset, whatever its chain bit.
            state_d = S_RST;
            rcnt_d  = RCW'(RESET_CYCLES - 1);
          end
        end
      end

      S_RST: begin
        if (rcnt_q == '0) begin
          state_d = S_EXEC;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end

      S_EXEC: begin
        if (mismatch) begin
          fail_d = fail_q + (AW+1)'(1);
          if (fail_q == '0) begin
            ffi_d = index_q;
          end
        end
        if (last_vec || (STOP_ON_FAIL && mismatch)) begin
          state_d = S_DONE;
          pass_d  = (fail_d == '0);
        end else begin
          index_d = index_inc;
          if (nxt_chain) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_RST;
            rcnt_d  = RCW'(RESET_CYCLES - 1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      n_q     <= '0;
      rcnt_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      n_q     <= n_d;
      rcnt_q  <= rcnt_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic drive_vec;
  assign drive_vec = (state_q == S_RST) || (state_q == S_EXEC);

  assign busy_o             = drive_vec;
  assign done_o             = (state_q == S_DONE);
  assign pass_o             = pass_q;
  assign fail_count_o       = fail_q;
  assign first_fail_index_o = ffi_q;

  // The CPU only runs free during EXEC; everywhere else it is held in reset.
  assign cpu_if.cpu_reset = (state_q != S_EXEC);
  assign cpu_if.instr     = drive_vec ? cur_vec[F_INSTR +: DATA_WIDTH] : '0;
  assign cpu_if.read_data = drive_vec ? cur_vec[F_RDATA +: DATA_WIDTH] : '0;

endmodule
